// File: rtl/irq_controller.sv
// Multi-source interrupt controller: latches request pulses, masks, arbitrates
// (fixed or rotating priority) and drives a single acknowledged irq line with payload.
module irq_controller #(
   parameter int unsigned NUM_SRC     = 4,
   parameter int unsigned ROUND_ROBIN = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_SRC-1:0]     srcReq,
   input  logic [16*NUM_SRC-1:0]  srcData,
   input  logic                   maskWe,
   input  logic [NUM_SRC-1:0]     maskIn,
   input  logic                   intEn,
   input  logic                   turnOffIRQ,
   output logic                   irq,
   output logic [15:0]            intData,
   output logic [2:0]             intSrc,
   output logic [NUM_SRC-1:0]     pending,
   output logic [NUM_SRC-1:0]     overflow
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned DIST_W = 4;

   typedef enum logic [1:0] {IDLE, ASSERT, RETIRE} state_e;

   state_e                 state_q, state_d;
   logic                   irq_q, irq_d;
   logic [DATA_W-1:0]      int_data_q, int_data_d;
   logic [IDX_W-1:0]       int_src_q, int_src_d;
   logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [NUM_SRC-1:0]     pending_q, pending_d;
   logic [NUM_SRC-1:0]     overflow_q, overflow_d;
   logic [NUM_SRC-1:0]     mask_q, mask_d;
   logic [DATA_W-1:0]      data_q [NUM_SRC];

   logic [NUM_SRC-1:0]     eligible_c;
   logic [NUM_SRC-1:0]     clr_c;
   logic                   ack_c;
   logic                   grant_vld_c;
   logic [IDX_W-1:0]       grant_idx_c;
   logic [DATA_W-1:0]      grant_data_c;
   logic [DIST_W-1:0]      dist_c;
   logic [DIST_W-1:0]      best_dist_c;

   // Per-source payload capture; a newer request simply overwrites older data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NUM_SRC; i++) data_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (srcReq[i]) data_q[i] <= srcData[DATA_W*i +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         irq_q      <= 1'b0;
         int_data_q <= '0;
         int_src_q  <= '0;
         rr_ptr_q   <= '0;
         pending_q  <= '0;
         overflow_q <= '0;
         mask_q     <= '1;
      end else begin
         state_q    <= state_d;
         irq_q      <= irq_d;
         int_data_q <= int_data_d;
         int_src_q  <= int_src_d;
         rr_ptr_q   <= rr_ptr_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         mask_q     <= mask_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      irq_d        = irq_q;
      int_data_d   = int_data_q;
      int_src_d    = int_src_q;
      rr_ptr_d     = rr_ptr_q;
      mask_d       = maskWe ? maskIn : mask_q;
      eligible_c   = pending_q & ~mask_q;
      ack_c        = (state_q == ASSERT) && turnOffIRQ;
      clr_c        = '0;
      grant_vld_c  = 1'b0;
      grant_idx_c  = '0;
      grant_data_c = '0;
      dist_c       = '0;
      best_dist_c  = '0;

      // Arbitration: rotating picks the eligible source nearest at/after rr_ptr.
      for (int unsigned j = 0; j < NUM_SRC; j++) begin
         if (ROUND_ROBIN != 0) begin
            if (DIST_W'(j) >= DIST_W'(rr_ptr_q)) dist_c = DIST_W'(j) - DIST_W'(rr_ptr_q);
            else dist_c = DIST_W'(j) + DIST_W'(NUM_SRC) - DIST_W'(rr_ptr_q);
         end else begin
            dist_c = DIST_W'(j);
         end
         if (eligible_c[j] && (!grant_vld_c || (dist_c < best_dist_c))) begin
            grant_vld_c = 1'b1;
            best_dist_c = dist_c;
            grant_idx_c = IDX_W'(j);
         end
      end
      for (int unsigned j = 0; j < NUM_SRC; j++) begin
         if (grant_idx_c == IDX_W'(j)) grant_data_c = data_q[j];
         if (ack_c && (int_src_q == IDX_W'(j))) clr_c[j] = 1'b1;
      end

      // A request on the clearing edge wins and is not an overflow.
      pending_d  = (pending_q & ~clr_c) | srcReq;
      overflow_d = overflow_q | (srcReq & pending_q & ~clr_c);

      case (state_q)
         IDLE: begin
            irq_d = 1'b0;
            if (intEn && grant_vld_c) begin
               state_d    = ASSERT;
               irq_d      = 1'b1;
               int_src_d  = grant_idx_c;
               int_data_d = grant_data_c;
            end
         end
         ASSERT: begin
            if (turnOffIRQ) begin
               state_d = RETIRE;
               irq_d   = 1'b0;
            end
         end
         RETIRE: begin
            irq_d   = 1'b0;
            state_d = IDLE;
            if (ROUND_ROBIN != 0) begin
               rr_ptr_d = (int_src_q == IDX_W'(NUM_SRC - 1)) ? '0 : int_src_q + IDX_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            irq_d   = 1'b0;
         end
      endcase
   end

   assign irq      = irq_q;
   assign intData  = int_data_q;
   assign intSrc   = int_src_q;
   assign pending  = pending_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: fixed-priority vector table plus reset and
// rotating-priority sequences.
module tb_irq_controller;

   logic        clk;
   logic        rst;
   logic [3:0]  srcReq;
   logic [63:0] srcData;
   logic        maskWe;
   logic [3:0]  maskIn;
   logic        intEn;
   logic        turnOffIRQ;
   logic        irq;
   logic [15:0] intData;
   logic [2:0]  intSrc;
   logic [3:0]  pending;
   logic [3:0]  overflow;

   logic [3:0]  rr_req;
   logic [63:0] rr_data;
   logic        rr_mwe;
   logic [3:0]  rr_min;
   logic        rr_en;
   logic        rr_ack;
   logic        rr_irq;
   logic [15:0] rr_int_data;
   logic [2:0]  rr_int_src;
   logic [3:0]  rr_pending;
   logic [3:0]  rr_overflow;

   int total;
   int passed;

   irq_controller #(.NUM_SRC(4), .ROUND_ROBIN(0)) dut_fp (
      .clk(clk), .rst(rst), .srcReq(srcReq), .srcData(srcData), .maskWe(maskWe),
      .maskIn(maskIn), .intEn(intEn), .turnOffIRQ(turnOffIRQ), .irq(irq),
      .intData(intData), .intSrc(intSrc), .pending(pending), .overflow(overflow)
   );

   irq_controller #(.NUM_SRC(4), .ROUND_ROBIN(1)) dut_rr (
      .clk(clk), .rst(rst), .srcReq(rr_req), .srcData(rr_data), .maskWe(rr_mwe),
      .maskIn(rr_min), .intEn(rr_en), .turnOffIRQ(rr_ack), .irq(rr_irq),
      .intData(rr_int_data), .intSrc(rr_int_src), .pending(rr_pending),
      .overflow(rr_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      logic [63:0] sdata;
      logic        mwe;
      logic [3:0]  min;
      logic        en;
      logic        ack;
      logic        irq;
      logic [15:0] data;
      logic [2:0]  src;
      logic [3:0]  pend;
      logic [3:0]  ovf;
   } vec_t;

   localparam int NVEC = 33;
   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic [3:0] req, input logic [63:0] sdata,
                               input logic mwe, input logic [3:0] min,
                               input logic en, input logic ack,
                               input logic e_irq, input logic [15:0] e_data,
                               input logic [2:0] e_src, input logic [3:0] e_pend,
                               input logic [3:0] e_ovf);
      vec_t v;
      v.req = req; v.sdata = sdata; v.mwe = mwe; v.min = min; v.en = en; v.ack = ack;
      v.irq = e_irq; v.data = e_data; v.src = e_src; v.pend = e_pend; v.ovf = e_ovf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rr_wait_irq(input string name);
      for (int c = 0; c < 10; c++) begin
         if (rr_irq) break;
         tick();
      end
      chk(name, 64'(rr_irq), 64'(1'b1));
   endtask

   initial begin
      int exp_src [5];
      logic [2:0] prev_src;

      total = 0; passed = 0;
      rst = 1'b0;
      srcReq = '0; srcData = '0; maskWe = 1'b0; maskIn = '0; intEn = 1'b0; turnOffIRQ = 1'b0;
      rr_req = '0; rr_data = '0; rr_mwe = 1'b0; rr_min = '0; rr_en = 1'b0; rr_ack = 1'b0;

      //                req      sdata                    mwe  min     en ack  irq data    src pend     ovf
      vecs[0]  = mk(4'b0010, 64'h0000_0000_001C_0000, 0, 4'b0000, 1, 0, 0, 16'h0000, 0, 4'b0010, 4'b0000);
      vecs[1]  = mk(4'b0000, 64'h0,                   0, 4'b0000, 1, 0, 0, 16'h0000, 0, 4'b0010, 4'b0000);
      vecs[2]  = mk(4'b0000, 64'h0,                   1, 4'b0000, 1, 0, 0, 16'h0000, 0, 4'b0010, 4'b0000);
      vecs[3]  = mk(4'b0000, 64'h0,                   0, 4'b0000, 1, 0, 1, 16'h001C, 1, 4'b0010, 4'b0000);
      vecs[4]  = mk(4'b0000, 64'h0,                   0, 4'b0000, 1, 1, 0, 16'h001C, 1, 4'b0000, 4'b0000);
      vecs[5]  = mk(4'b0000, 64'h0,                   0, 4'b0000, 1, 0, 0, 16'h001C, 1, 4'b0000, 4'b0000);
      vecs[6]  = mk(4'b1001, 64'h3333_0000_0000_0A0A, 0, 4'b0000, 1, 0, 0, 16'h001C, 1, 4'b1001, 4'b0000);
      vecs[7]  = mk(4'b0000, 64'h0,                   0, 4'b0000, 1, 0, 1, 16'h0A0A, 0, 4'b1001, 4'b0000);
      vecs[8]  = mk(4'b0000, 64'h0,                   0, 4'b0000, 1, 0, 1, 16'h0A0A, 0, 4'b1001, 4'b0000);
      vecs[9]  = mk(4'b0000, 64'h0,                   0, 4'b0000, 1, 1, 0, 16'h0A0A, 0, 4'b1000, 4'b0000);
      vecs[10] = mk(4'b0000, 64'h0,                   0, 4'b0000, 1, 0, 0, 16'h0A0A, 0, 4'b1000, 4'b0000);
      vecs[11] = mk(4'b0000, 64'h0,                   0, 4'b0000, 1, 0, 1, 16'h3333, 3, 4'b1000, 4'b0000);
      vecs[12] = mk(4'b0000, 64'h0,                   0, 4'b0000, 1, 1, 0, 16'h3333, 3, 4'b0000, 4'b0000);
      vecs[13] = mk(4'b0000, 64'h0,                   0, 4'b0000, 1, 0, 0, 16'h3333, 3, 4'b0000, 4'b0000);
      vecs[14] = mk(4'b0000, 64'h0,                   1, 4'b0010, 1, 0, 0, 16'h3333, 3, 4'b0000, 4'b0000);
      vecs[15] = mk(4'b0010, 64'h0000_0000_0111_0000, 0, 4'b0000, 1, 0, 0, 16'h3333, 3, 4'b0010, 4'b0000);
      vecs[16] = mk(4'b0000, 64'h0,                   0, 4'b0000, 1, 0, 0, 16'h3333, 3, 4'b0010, 4'b0000);
      vecs[17] = mk(4'b0000, 64'h0,                   1, 4'b0000, 1, 0, 0, 16'h3333, 3, 4'b0010, 4'b0000);
      vecs[18] = mk(4'b0000, 64'h0,                   0, 4'b0000, 0, 1, 0, 16'h3333, 3, 4'b0010, 4'b0000);
      vecs[19] = mk(4'b0000, 64'h0,                   0, 4'b0000, 0, 0, 0, 16'h3333, 3, 4'b0010, 4'b0000);
      vecs[20] = mk(4'b0000, 64'h0,                   0, 4'b0000, 1, 0, 1, 16'h0111, 1, 4'b0010, 4'b0000);
      vecs[21] = mk(4'b0000, 64'h0,                   0, 4'b0000, 1, 1, 0, 16'h0111, 1, 4'b0000, 4'b0000);
      vecs[22] = mk(4'b0000, 64'h0,                   0, 4'b0000, 1, 0, 0, 16'h0111, 1, 4'b0000, 4'b0000);
      vecs[23] = mk(4'b0100, 64'h0000_1111_0000_0000, 0, 4'b0000, 0, 0, 0, 16'h0111, 1, 4'b0100, 4'b0000);
      vecs[24] = mk(4'b0100, 64'h0000_2222_0000_0000, 0, 4'b0000, 0, 0, 0, 16'h0111, 1, 4'b0100, 4'b0100);
      vecs[25] = mk(4'b0000, 64'h0,                   0, 4'b0000, 1, 0, 1, 16'h2222, 2, 4'b0100, 4'b0100);
      vecs[26] = mk(4'b0100, 64'h0000_3333_0000_0000, 0, 4'b0000, 1, 1, 0, 16'h2222, 2, 4'b0100, 4'b0100);
      vecs[27] = mk(4'b0000, 64'h0,                   0, 4'b0000, 1, 0, 0, 16'h2222, 2, 4'b0100, 4'b0100);
      vecs[28] = mk(4'b0000, 64'h0,                   0, 4'b0000, 1, 0, 1, 16'h3333, 2, 4'b0100, 4'b0100);
      vecs[29] = mk(4'b0001, 64'h0000_0000_0000_0005, 0, 4'b0000, 0, 0, 1, 16'h3333, 2, 4'b0101, 4'b0100);
      vecs[30] = mk(4'b0000, 64'h0,                   0, 4'b0000, 1, 1, 0, 16'h3333, 2, 4'b0001, 4'b0100);
      vecs[31] = mk(4'b0000, 64'h0,                   0, 4'b0000, 1, 0, 0, 16'h3333, 2, 4'b0001, 4'b0100);
      vecs[32] = mk(4'b0000, 64'h0,                   0, 4'b0000, 1, 0, 1, 16'h0005, 0, 4'b0001, 4'b0100);

      repeat (2) @(posedge clk);
      #1;
      chk("reset irq",      64'(irq),      64'(0));
      chk("reset intData",  64'(intData),  64'(0));
      chk("reset intSrc",   64'(intSrc),   64'(0));
      chk("reset pending",  64'(pending),  64'(0));
      chk("reset overflow", 64'(overflow), 64'(0));
      rst = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         srcReq = vecs[i].req; srcData = vecs[i].sdata; maskWe = vecs[i].mwe;
         maskIn = vecs[i].min; intEn = vecs[i].en; turnOffIRQ = vecs[i].ack;
         tick();
         chk($sformatf("row%0d irq", i),      64'(irq),      64'(vecs[i].irq));
         chk($sformatf("row%0d intData", i),  64'(intData),  64'(vecs[i].data));
         chk($sformatf("row%0d intSrc", i),   64'(intSrc),   64'(vecs[i].src));
         chk($sformatf("row%0d pending", i),  64'(pending),  64'(vecs[i].pend));
         chk($sformatf("row%0d overflow", i), 64'(overflow), 64'(vecs[i].ovf));
      end
      srcReq = '0; srcData = '0; maskWe = 1'b0; intEn = 1'b0; turnOffIRQ = 1'b0;

      // Asynchronous reset while irq is high
      chk("pre-reset irq", 64'(irq), 64'(1));
      rst = 1'b0;
      #1;
      chk("async irq",      64'(irq),      64'(0));
      chk("async pending",  64'(pending),  64'(0));
      chk("async overflow", 64'(overflow), 64'(0));
      chk("async intData",  64'(intData),  64'(0));
      chk("async intSrc",   64'(intSrc),   64'(0));
      tick();
      rst = 1'b1;
      intEn = 1'b1; srcReq = 4'b0001; srcData = 64'h0000_0000_0000_00AB;
      tick();
      srcReq = '0;
      repeat (3) tick();
      chk("mask reset irq",     64'(irq),     64'(0));
      chk("mask reset pending", 64'(pending), 64'(4'b0001));
      intEn = 1'b0;

      // Rotating priority with all sources re-requested after every ack
      exp_src[0] = 0; exp_src[1] = 1; exp_src[2] = 2; exp_src[3] = 3; exp_src[4] = 0;
      prev_src = 3'd7;
      rr_mwe = 1'b1; rr_min = 4'b0000; rr_en = 1'b1;
      tick();
      rr_mwe = 1'b0;
      rr_req = 4'b1111; rr_data = 64'h0004_0003_0002_0001;
      tick();
      rr_req = '0;
      for (int k = 0; k < 5; k++) begin
         rr_wait_irq($sformatf("rr%0d irq timeout", k));
         chk($sformatf("rr%0d intSrc", k),  64'(rr_int_src),  64'(exp_src[k]));
         chk($sformatf("rr%0d intData", k), 64'(rr_int_data), 64'(exp_src[k] + 1));
         chk($sformatf("rr%0d repeat", k),  64'(rr_int_src != prev_src), 64'(1));
         prev_src = rr_int_src;
         rr_ack = 1'b1;
         tick();
         rr_ack = 1'b0;
         chk($sformatf("rr%0d irq low", k), 64'(rr_irq), 64'(0));
         rr_req = 4'b1111;
         tick();
         rr_req = '0;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
